// File: rtl/fifo_dualbank_vr.sv
// fifo_dualbank_vr: valid/ready FIFO built on two single-port RAM banks.
//
// Even pointer values live in bank 0 and odd ones in bank 1, so one write and one read can
// happen in the same cycle as long as they fall in different banks. A two-entry registered
// prefetch buffer (ob) feeds the output, so out_valid/out_data come straight from flops.
// in_ready depends only on the registered count, flush and rst_n; it has no path from
// out_ready.
//
// Ports:
//   clk          sole clock, all state updates on posedge
//   rst_n        synchronous active-low reset; clears everything that flush clears
//   flush        synchronous clear of all contents (RAM contents left as they are)
//   in_data      write payload
//   in_valid     write request; accept = in_valid & in_ready
//   in_ready     FIFO can take an entry this cycle
//   out_data     head entry (registered)
//   out_valid    head entry valid (registered)
//   out_ready    consumer pop; pop = out_valid & out_ready
//   count        entries held (RAM + in-flight read + prefetch buffer)
//   almost_full  count >= AF_LEVEL
//   almost_empty count <= AE_LEVEL
module fifo_dualbank_vr #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned AF_LEVEL   = FIFO_DEPTH - 2,
  parameter int unsigned AE_LEVEL   = 1,
  parameter int unsigned CNT_WIDTH  = $clog2(FIFO_DEPTH + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [CNT_WIDTH-1:0]  count,
  output logic                  almost_full,
  output logic                  almost_empty
);

  localparam int unsigned PtrW      = $clog2(FIFO_DEPTH);
  localparam int unsigned AddrW     = PtrW - 1;
  localparam int unsigned BankDepth = FIFO_DEPTH / 2;

  localparam logic [CNT_WIDTH-1:0] DepthCnt = CNT_WIDTH'(FIFO_DEPTH);
  localparam logic [CNT_WIDTH-1:0] AfCnt    = CNT_WIDTH'(AF_LEVEL);
  localparam logic [CNT_WIDTH-1:0] AeCnt    = CNT_WIDTH'(AE_LEVEL);

  // ---------------------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------------------
  logic [PtrW-1:0]                   wptr_q, wptr_d;
  logic [PtrW-1:0]                   rptr_q, rptr_d;
  logic [CNT_WIDTH-1:0]              count_q, count_d;
  logic [CNT_WIDTH-1:0]              ram_cnt_q, ram_cnt_d;
  logic                              inflight_q, inflight_d;
  logic                              inflight_bank_q, inflight_bank_d;
  logic [1:0]                        ob_cnt_q, ob_cnt_d;
  logic [1:0][DATA_WIDTH-1:0]        ob_data_q, ob_data_d;

  // ---------------------------------------------------------------------------------------
  // Handshakes and read-issue decision
  // ---------------------------------------------------------------------------------------
  logic       accept;
  logic       pop;
  logic       wr_bank;
  logic       rd_bank;
  logic [2:0] ob_occ;
  logic       ob_room;
  logic       issue;

  assign in_ready = ~flush & rst_n & (count_q < DepthCnt);
  assign accept   = in_valid & in_ready;
  assign pop      = out_valid & out_ready;
  assign wr_bank  = wptr_q[0];
  assign rd_bank  = rptr_q[0];

  // Buffer slots already committed (held + returning). A new read may go out only if its
  // data will still fit when it lands next cycle, counting the pop happening now.
  assign ob_occ  = {1'b0, ob_cnt_q} + {2'b00, inflight_q};
  assign ob_room = ob_occ <= (3'd1 + {2'b00, pop});

  // Writes own their bank; a read aimed at the bank being written waits one cycle, which
  // puts the two pointers out of phase for subsequent streaming.
  assign issue = ~flush & (ram_cnt_q != '0) & ob_room & ~(accept & (wr_bank == rd_bank));

  // ---------------------------------------------------------------------------------------
  // RAM banks (single port, registered read data, enable tied to rst_n)
  // ---------------------------------------------------------------------------------------
  logic [1:0]                 bank_we;
  logic [1:0][AddrW-1:0]      bank_addr;
  logic [1:0][DATA_WIDTH-1:0] bank_rdata;

  always_comb begin
    bank_we[0]   = accept & ~wr_bank;
    bank_we[1]   = accept & wr_bank;
    bank_addr[0] = bank_we[0] ? wptr_q[PtrW-1:1] : rptr_q[PtrW-1:1];
    bank_addr[1] = bank_we[1] ? wptr_q[PtrW-1:1] : rptr_q[PtrW-1:1];
  end

  for (genvar b = 0; b < 2; b++) begin : g_bank
    logic [DATA_WIDTH-1:0] mem_q [BankDepth];
    logic [DATA_WIDTH-1:0] douta_q;

    always_ff @(posedge clk) begin
      if (rst_n) begin
        if (bank_we[b]) begin
          mem_q[bank_addr[b]] <= in_data;
        end else begin
          douta_q <= mem_q[bank_addr[b]];
        end
      end
    end

    assign bank_rdata[b] = douta_q;
  end

  // ---------------------------------------------------------------------------------------
  // Next-state logic
  // ---------------------------------------------------------------------------------------
  logic [1:0] ob_after_pop;

  always_comb begin
    wptr_d          = wptr_q;
    rptr_d          = rptr_q;
    count_d         = count_q;
    ram_cnt_d       = ram_cnt_q;
    inflight_d      = issue;
    inflight_bank_d = rd_bank;
    ob_data_d       = ob_data_q;
    ob_after_pop    = ob_cnt_q - {1'b0, pop};

    if (accept) begin
      wptr_d = wptr_q + PtrW'(1);
    end
    if (issue) begin
      rptr_d = rptr_q + PtrW'(1);
    end

    ram_cnt_d = ram_cnt_q + CNT_WIDTH'(accept) - CNT_WIDTH'(issue);

    unique case ({accept, pop})
      2'b10:   count_d = count_q + CNT_WIDTH'(1);
      2'b01:   count_d = count_q - CNT_WIDTH'(1);
      default: count_d = count_q;
    endcase

    // Shift on pop, then append the returning read behind whatever is left.
    if (pop) begin
      ob_data_d[0] = ob_data_q[1];
    end
    if (inflight_q) begin
      if (ob_after_pop == 2'd0) begin
        ob_data_d[0] = bank_rdata[inflight_bank_q];
      end else begin
        ob_data_d[1] = bank_rdata[inflight_bank_q];
      end
    end
    ob_cnt_d = ob_after_pop + {1'b0, inflight_q};

    // Flush discards everything, including a read still on its way back.
    if (flush) begin
      wptr_d     = '0;
      rptr_d     = '0;
      count_d    = '0;
      ram_cnt_d  = '0;
      inflight_d = 1'b0;
      ob_cnt_d   = '0;
      ob_data_d  = '0;
    end
  end

  // ---------------------------------------------------------------------------------------
  // State registers
  // ---------------------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      wptr_q          <= '0;
      rptr_q          <= '0;
      count_q         <= '0;
      ram_cnt_q       <= '0;
      inflight_q      <= 1'b0;
      inflight_bank_q <= 1'b0;
      ob_cnt_q        <= '0;
      ob_data_q       <= '0;
    end else begin
      wptr_q          <= wptr_d;
      rptr_q          <= rptr_d;
      count_q         <= count_d;
      ram_cnt_q       <= ram_cnt_d;
      inflight_q      <= inflight_d;
      inflight_bank_q <= inflight_bank_d;
      ob_cnt_q        <= ob_cnt_d;
      ob_data_q       <= ob_data_d;
    end
  end

  // ---------------------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------------------
  assign out_valid    = ob_cnt_q != 2'd0;
  assign out_data     = ob_data_q[0];
  assign count        = count_q;
  assign almost_full  = count_q >= AfCnt;
  assign almost_empty = count_q <= AeCnt;

endmodule

// File: tb/tb_fifo_dualbank_vr.sv
// Self-checking bench for fifo_dualbank_vr. The reference model is a plain queue of entries
// (with the cycle each was accepted); count, flags, ready and head data are derived from it.
// Output liveness is bounded: the head entry must be presented within a few cycles of it
// becoming the oldest entry.
module tb_fifo_dualbank_vr;

  localparam int DEPTH = 16;
  localparam int AF    = DEPTH - 2;
  localparam int AE    = 1;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic [7:0]    in_data;
  logic          in_valid;
  logic          in_ready;
  logic [7:0]    out_data;
  logic          out_valid;
  logic          out_ready;
  logic [CW-1:0] count;
  logic          almost_full;
  logic          almost_empty;

  always #5 clk = ~clk;

  fifo_dualbank_vr #(
    .DATA_WIDTH(8),
    .FIFO_DEPTH(DEPTH),
    .AF_LEVEL  (AF),
    .AE_LEVEL  (AE)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .flush       (flush),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .out_data    (out_data),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .count       (count),
    .almost_full (almost_full),
    .almost_empty(almost_empty)
  );

  logic [7:0] q[$];
  int         qt[$];
  int         cyc        = 0;
  int         head_since = 0;
  int         pops       = 0;
  int         first_acc  = -1;
  int         first_ov   = -1;
  int         total      = 0;
  int         bad        = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock cycle: drive at negedge, check ready, advance model at posedge, check state.
  task automatic step(input logic iv, input logic [7:0] d, input logic ordy, input logic fl,
                      input logic rn);
    logic exp_ir;
    logic acc;
    logic pp;
    int   ready_t;
    in_valid  = iv;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    rst_n     = rn;
    #1;
    exp_ir = rn && !fl && (q.size() < DEPTH);
    chk("in_ready", 32'(in_ready), 32'(exp_ir));
    acc = iv && exp_ir;
    pp  = out_valid && ordy && rn && !fl;
    @(posedge clk);
    cyc++;
    if (!rn || fl) begin
      q.delete();
      qt.delete();
    end else begin
      if (pp && q.size() > 0) begin
        void'(q.pop_front());
        void'(qt.pop_front());
        head_since = cyc;
        pops++;
      end
      if (acc) begin
        q.push_back(d);
        qt.push_back(cyc);
        if (first_acc < 0) first_acc = cyc;
      end
    end
    @(negedge clk);
    chk("count", 32'(count), 32'(q.size()));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AF));
    chk("almost_empty", 32'(almost_empty), 32'(q.size() <= AE));
    if (q.size() == 0) begin
      chk("ov_empty", 32'(out_valid), 32'd0);
    end else begin
      if (out_valid) chk("out_data", 32'(out_data), 32'(q[0]));
      ready_t = (qt[0] > head_since) ? qt[0] : head_since;
      if (cyc - ready_t >= 5) chk("ov_live", 32'(out_valid), 32'd1);
    end
    if (out_valid && first_ov < 0) first_ov = cyc;
  endtask

  task automatic drain(input string tag);
    for (int i = 0; i < 60 && q.size() > 0; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk(tag, 32'(q.size()), 32'd0);
  endtask

  initial begin
    int p0;
    rst_n     = 1'b0;
    flush     = 1'b0;
    in_valid  = 1'b0;
    in_data   = '0;
    out_ready = 1'b0;
    @(negedge clk);

    // Reset state
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("rst_out_data", 32'(out_data), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_almost_empty", 32'(almost_empty), 32'd1);

    // Three back-to-back writes with a ready consumer: first out_valid two edges after accept
    first_acc = -1;
    first_ov  = -1;
    pops      = 0;
    for (int i = 1; i <= 3; i++) step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("latency", 32'(first_ov - first_acc), 32'd2);
    chk("three_pops", 32'(pops), 32'd3);
    chk("three_drained", 32'(count), 32'd0);

    // Fill with no consumer; the 17th request must be refused
    for (int i = 0; i < DEPTH + 1; i++) step(1'b1, 8'(8'h40 + i), 1'b0, 1'b0, 1'b1);
    chk("full_count", 32'(count), 32'(DEPTH));
    chk("full_in_ready", 32'(in_ready), 32'd0);
    chk("full_almost_full", 32'(almost_full), 32'd1);

    // Stream from full for 100 cycles across pointer wrap: one pop per cycle after ramp
    p0 = 0;
    for (int i = 0; i < 100; i++) begin
      if (i == 10) p0 = pops;
      step(1'b1, 8'(i), 1'b1, 1'b0, 1'b1);
    end
    chk("stream_pops", 32'(pops - p0), 32'd90);
    drain("stream_drain");

    // Flush while a read is returning; afterwards a single new entry emerges alone
    for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h10 + i), 1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b1, 1'b1, 1'b1);
    chk("flush_count", 32'(count), 32'd0);
    chk("flush_out_valid", 32'(out_valid), 32'd0);
    chk("flush_almost_empty", 32'(almost_empty), 32'd1);
    p0 = pops;
    step(1'b1, 8'hAA, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 8; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    chk("flush_single_pop", 32'(pops - p0), 32'd1);

    // Reset for one edge with 8 entries held
    for (int i = 0; i < 8; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0, 1'b1);
    step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    chk("mid_rst_out_valid", 32'(out_valid), 32'd0);
    chk("mid_rst_out_data", 32'(out_data), 32'd0);
    chk("mid_rst_count", 32'(count), 32'd0);
    step(1'b0, 8'h00, 1'b1, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 8'(8'h70 + i), 1'b1, 1'b0, 1'b1);
    drain("post_rst_drain");

    // Random traffic with rare flushes
    for (int i = 0; i < 10000; i++) begin
      step(1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
           1'($urandom_range(0, 499) == 0), 1'b1);
    end
    drain("random_drain");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/fifo_dualbank_vr.md
# fifo_dualbank_vr

Parametrised valid/ready FIFO built on two single-port RAM banks (even/odd entries), sustaining one write and one read per cycle with no combinational path from out_ready to in_ready. Output is served from a 2-entry registered prefetch buffer. Adds flush, occupancy count and almost-full/almost-empty flags. Drop-in successor for single-bank spram FIFOs on streaming datapaths.

## Interface
- DATA_WIDTH, 8, payload width
- FIFO_DEPTH, 16, total capacity in entries (RAM plus prefetch buffer); power of two, >= 4
- AF_LEVEL, FIFO_DEPTH-2, almost_full asserted when count >= AF_LEVEL
- AE_LEVEL, 1, almost_empty asserted when count <= AE_LEVEL
- CNT_WIDTH, $clog2(FIFO_DEPTH+1), derived, width of count
- clk  in  1  sole clock, all logic on posedge
- rst_n  in  1  synchronous reset, active-low
- flush  in  1  synchronous clear of all contents
- in_data  in  DATA_WIDTH  write payload
- in_valid  in  1  write request
- in_ready  out  1  FIFO can accept; accept = in_valid & in_ready
- out_data  out  DATA_WIDTH  head entry, registered
- out_valid  out  1  head valid, registered
- out_ready  in  1  consumer pop; pop = out_valid & out_ready
- count  out  CNT_WIDTH  entries held (RAM + in-flight + prefetch)
- almost_full  out  1  count >= AF_LEVEL
- almost_empty  out  1  count <= AE_LEVEL

## Operation
- Storage: two spram banks, each FIFO_DEPTH/2 deep. Entry at pointer p lives in bank p[0], address p>>1. Write pointer wptr, read-issue pointer rptr, log2(FIFO_DEPTH) bits, wrap naturally.
- in_ready = ~flush & rst_n & (count < FIFO_DEPTH), from registered count only; independent of out_ready.
- Write: on accept, in_data written to bank wptr[0] the same cycle; wptr += 1. Writes always win their bank.
- Read issue: prefetch engine issues a read of bank rptr[0] when ram_cnt > 0 (registered), (ob_cnt + inflight - pop) <= 1, and bank rptr[0] is not being written this cycle. On issue rptr += 1, ram_cnt -= 1, inflight set.
- Bank collision (write and candidate read on same bank): read deferred one cycle; pointers then fall out of phase, so streaming sustains 1/cycle.
- Return: douta of the issued bank captured into prefetch buffer ob (2 entries, FIFO order) at the end of the cycle after issue; inflight cleared.
- out_valid = ob_cnt != 0; out_data = ob head register.
- count: +1 on accept, -1 on pop, unchanged on both; ram_cnt updated by accept/issue.
- flush (sync): pointers, ram_cnt, ob_cnt, inflight, count cleared next edge; in-flight read data discarded; accept blocked in flush cycle; pop in flush cycle ignored. RAM contents untouched.
- spram ena tied to rst_n per bank; wea = write this cycle to that bank; addr = write address if writing, else read address.

## Timing
- Reset (rst_n low at edge): out_valid 0, out_data 0, count 0, almost_full 0, almost_empty 1; in_ready 0 while rst_n low, 1 the cycle after release.
- Reset mid-operation: identical to flush; all content lost, no partial entries emerge.
- Latency: accept in cycle t -> RAM write end of t -> read issue t+1 -> ob load end of t+2 -> out_valid high cycle t+3 (empty FIFO, no collision).
- Throughput: one accept and one pop per cycle sustained; collisions cost at most one issue slot, absorbed by ob.
- Full: count == FIFO_DEPTH -> in_ready 0; pop at full raises in_ready next cycle (no same-cycle pass-through).
- Empty: out_valid 0; accept and pop in same cycle impossible when count == 0.
- Simultaneous accept and pop: count unchanged, flags unchanged.
- Flags are registered-derived from count, valid same cycle as count.

## Test plan
- Reset then write 0x01..0x03 back-to-back, out_ready=1 -> out_valid first high 3 cycles after first accept; out_data 0x01,0x02,0x03 consecutive; count returns to 0.
- Fill 16 entries (DEPTH=16) with out_ready=0 -> in_ready drops after 16th accept; count 16; almost_full high from count 14; 17th in_valid not accepted.
- Full FIFO, in_valid=1 and out_ready=1 for 100 cycles with counting pattern -> in-order data, one pop per cycle after ramp, no loss or duplication across pointer wrap.
- Random in_valid/out_ready (50%) for 10k cycles against scoreboard -> exact order match, count equals scoreboard depth every cycle, flags consistent.
- Load 5 entries, assert flush for one cycle during a pending read -> next cycle count 0, out_valid 0, almost_empty 1; subsequent write 0xAA emerges alone.
- Assert rst_n=0 for one edge with 8 entries held -> outputs at reset values next cycle; in_ready 1 after release; stale data never appears.
